// File: rtl/seg_display_ctrl_if.sv
// Bus between the game core and the seven-segment display sequencer.
// The master drives the game state; the slave returns the digit data
// for the scanning display driver.
interface seg_display_ctrl_if;
    logic [13:0] score;
    logic [13:0] lines;
    logic [3:0]  level;
    logic        score_upd;
    logic        paused;
    logic        game_over;
    logic [15:0] HEXS;
    logic [3:0]  EN;
    logic [3:0]  P;
    logic        busy;

    modport master (
        output score, lines, level, score_upd, paused, game_over,
        input  HEXS, EN, P, busy
    );

    modport slave (
        input  score, lines, level, score_upd, paused, game_over,
        output HEXS, EN, P, busy
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Tetris score display sequencer: rotates score / lines / level pages,
// converts the selected value to BCD with a free-running shift-add-3
// engine, then applies leading-zero blanking, page markers and the
// game-over blink.
module seg_display_ctrl #(
    parameter int unsigned PAGE_TICKS  = 50_000_000,
    parameter int unsigned HOLD_TICKS  = 100_000_000,
    parameter int unsigned BLINK_TICKS = 25_000_000
) (
    input logic               clk,
    input logic               rst,
    seg_display_ctrl_if.slave bus
);
    localparam int PAGE_W  = $clog2(PAGE_TICKS + 1);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [1:0] PG_SCORE = 2'd0;
    localparam logic [1:0] PG_LINES = 2'd1;
    localparam logic [1:0] PG_LEVEL = 2'd2;

    // Clamp to what four decimal digits can show.
    function automatic logic [13:0] sat_9999(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Light everything from the most significant nonzero digit down; digit 0 always lit.
    function automatic logic [3:0] lz_enable(input logic [15:0] b);
        logic [3:0] e;
        e[3] = |b[15:12];
        e[2] = e[3] | (|b[11:8]);
        e[1] = e[2] | (|b[7:4]);
        e[0] = 1'b1;
        return e;
    endfunction

    // Active-low decimal point pattern identifying the page on screen.
    function automatic logic [3:0] page_marker(input logic [1:0] pg);
        case (pg)
            PG_LINES: return 4'b1011;
            PG_LEVEL: return 4'b0111;
            default:  return 4'b1111;
        endcase
    endfunction

    logic [1:0]         state_q, state_d;
    logic [3:0]         shift_cnt_q, shift_cnt_d;
    logic [13:0]        bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        bcd_adj;
    logic [1:0]         conv_page_q, conv_page_d;
    logic [15:0]        hexs_q, hexs_d;
    logic [3:0]         en_q, en_d;
    logic [3:0]         p_q, p_d;
    logic [13:0]        page_value;
    logic [1:0]         page_q, page_d;
    logic [PAGE_W-1:0]  page_cnt_q, page_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Page selection: game-over freeze beats score-update hold beats rotation.
    always_comb begin
        page_d      = page_q;
        page_cnt_d  = page_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (bus.game_over) begin
            page_d = PG_SCORE;
            if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
            if (bus.score_upd) begin
                page_d     = PG_SCORE;
                hold_cnt_d = HOLD_W'(HOLD_TICKS);
                page_cnt_d = '0;
            end else if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end else if (page_cnt_q == PAGE_W'(PAGE_TICKS - 1)) begin
                page_cnt_d = '0;
                page_d     = (page_q == PG_LEVEL) ? PG_SCORE : page_q + 2'd1;
            end else begin
                page_cnt_d = page_cnt_q + 1'b1;
            end
        end
    end

    // Value shown on the page currently selected.
    always_comb begin
        case (page_q)
            PG_SCORE: page_value = bus.score;
            PG_LINES: page_value = bus.lines;
            default:  page_value = {10'b0, bus.level};
        endcase
    end

    // Conversion FSM: LOAD latches the page value, 14 SHIFTs build BCD, COMMIT publishes.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        conv_page_d = conv_page_q;
        hexs_d      = hexs_q;
        en_d        = en_q;
        p_d         = p_q;
        bcd_adj     = add3_nibbles(bcd_q);
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                bin_d       = sat_9999(page_value);
                bcd_d       = '0;
                conv_page_d = page_q;
                shift_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                if (shift_cnt_q == 4'd13) state_d = ST_COMMIT;
                else shift_cnt_d = shift_cnt_q + 1'b1;
            end
            ST_COMMIT: begin
                hexs_d  = bcd_q;
                en_d    = lz_enable(bcd_q);
                p_d     = page_marker(conv_page_q) & {3'b111, ~bus.paused};
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and visible output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            hexs_q      <= 16'h0000;
            en_q        <= 4'b0001;
            p_q         <= 4'b1111;
            page_q      <= PG_SCORE;
            page_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            hexs_q      <= hexs_d;
            en_q        <= en_d;
            p_q         <= p_d;
            page_q      <= page_d;
            page_cnt_q  <= page_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    // Conversion datapath; always rewritten at LOAD before it is used.
    always_ff @(posedge clk) begin
        bin_q       <= bin_d;
        bcd_q       <= bcd_d;
        conv_page_q <= conv_page_d;
    end

    assign bus.HEXS = hexs_q;
    assign bus.EN   = en_q & {4{~blink_off_q}};
    assign bus.P    = p_q;
    assign bus.busy = (state_q != ST_IDLE);
endmodule
